// File: rtl/pc_sequencer.sv
// pc_sequencer
// Owns the architectural fetch PC and chooses its next value every cycle.
// The sources, from highest priority to lowest, are: trap vector, jump
// target, branch target, sequential step. Holding keeps the current value.
// A stall or an instruction memory that is not ready freezes the PC. A
// redirect raises a flush pulse and then suppresses fetch for a
// programmable number of bubble cycles.
//
// Ports:
//   clock          rising-edge system clock
//   resetn         asynchronous active-low reset
//   stall          pipeline hazard stall, holds the PC
//   imem_ready     instruction memory accepts a fetch this cycle
//   branch_taken   conditional branch resolved taken
//   branch_target  branch destination
//   jump_valid     unconditional jump request
//   jump_target    jump destination
//   exception      synchronous trap request (always vectors to TRAP_PC)
//   pc             current fetch address (registered)
//   next_pc        value pc takes at the next edge (combinational)
//   fetch_valid    pc is a valid fetch request this cycle
//   flush          one-cycle pulse after a redirect is taken
//   misaligned     one-cycle pulse with flush when the target was misaligned
module pc_sequencer #(
    parameter logic [31:0] RESET_PC         = 32'd100,
    parameter logic [31:0] PC_STEP          = 32'd4,
    parameter logic [31:0] TRAP_PC          = 32'd8,
    parameter int          REDIRECT_BUBBLES = 1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_valid,
    input  logic [31:0] jump_target,
    input  logic        exception,
    output logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        fetch_valid,
    output logic        flush,
    output logic        misaligned
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD,
        REDIRECT
    } state_t;

    // The counter holds the number of bubble cycles still to come after the
    // current one, so a single bubble reloads it to zero.
    localparam logic [1:0] BUBBLE_RELOAD = 2'(REDIRECT_BUBBLES - 1);

    state_t      state;
    logic [1:0]  bubble_cnt;

    logic        redirect_req;
    logic        hold_req;
    logic        advance;
    logic [31:0] raw_target;
    logic        target_misaligned;
    logic [31:0] redirect_pc;

    // Select the redirect target by priority. A misaligned jump or branch
    // target becomes the trap vector. Redirects are not accepted in BOOT.
    always_comb begin
        raw_target        = branch_target;
        target_misaligned = 1'b0;
        if (exception) begin
            raw_target = TRAP_PC;
        end else if (jump_valid) begin
            raw_target        = jump_target;
            target_misaligned = (jump_target[1:0] != 2'b00);
        end else begin
            raw_target        = branch_target;
            target_misaligned = (branch_target[1:0] != 2'b00);
        end
        redirect_pc  = target_misaligned ? TRAP_PC : raw_target;
        redirect_req = (state != BOOT) && (exception || jump_valid || branch_taken);
        hold_req     = stall || !imem_ready;
        advance      = fetch_valid && !hold_req;
    end

    // next_pc is the single source of the PC update. The register below
    // loads it every cycle, so next_pc always matches the value pc takes
    // at the next edge.
    always_comb begin
        next_pc = pc;
        if (redirect_req) begin
            next_pc = redirect_pc;
        end else if (advance) begin
            next_pc = pc + PC_STEP;
        end
    end

    // State machine with registered outputs. A redirect overrides stall,
    // imem_ready and any pending bubble countdown. This includes a redirect
    // that arrives while bubbles are already in progress.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            fetch_valid <= 1'b0;
            flush       <= 1'b0;
            misaligned  <= 1'b0;
            bubble_cnt  <= 2'd0;
        end else begin
            pc         <= next_pc;
            flush      <= 1'b0;
            misaligned <= 1'b0;
            if (state == BOOT) begin
                state       <= RUN;
                fetch_valid <= 1'b1;
            end else if (redirect_req) begin
                state       <= REDIRECT;
                fetch_valid <= 1'b0;
                flush       <= 1'b1;
                misaligned  <= target_misaligned;
                bubble_cnt  <= BUBBLE_RELOAD;
            end else if (state == REDIRECT) begin
                if (bubble_cnt == 2'd0) begin
                    state       <= hold_req ? HOLD : RUN;
                    fetch_valid <= 1'b1;
                end else begin
                    bubble_cnt <= bubble_cnt - 2'd1;
                end
            end else begin
                state       <= hold_req ? HOLD : RUN;
                fetch_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Directed bench for pc_sequencer. Each stimulus step drives one cycle of
// inputs just after a rising edge. It also pushes the hand-computed outputs
// for that cycle into a queue. A monitor samples on the falling edge, pops
// one expectation and compares it against the DUT.
module tb_pc_sequencer;

    logic        clock;
    logic        resetn;
    logic        stall;
    logic        imem_ready;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump_valid;
    logic [31:0] jump_target;
    logic        exception;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        fetch_valid;
    logic        flush;
    logic        misaligned;

    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic [31:0] np;
        logic        fv;
        logic        fl;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   compared;
    int   mismatched;
    int   step_idx;

    pc_sequencer #(
        .RESET_PC(32'd100),
        .PC_STEP(32'd4),
        .TRAP_PC(32'd8),
        .REDIRECT_BUBBLES(1)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .stall(stall),
        .imem_ready(imem_ready),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .jump_valid(jump_valid),
        .jump_target(jump_target),
        .exception(exception),
        .pc(pc),
        .next_pc(next_pc),
        .fetch_valid(fetch_valid),
        .flush(flush),
        .misaligned(misaligned)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Compare one value and record the outcome in the shared counters.
    task automatic check_output(input string name, input int idx,
                                input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s step %0d: got 0x%08h, expected 0x%08h",
                     name, idx, actual, expected);
        end
    endtask

    // Drive one cycle of inputs after the next rising edge. Queue the
    // outputs expected during that cycle.
    task automatic apply_stimulus(input logic rst, input logic s, input logic r,
                                  input logic bt_en, input logic [31:0] bt,
                                  input logic jv, input logic [31:0] jt,
                                  input logic exc,
                                  input logic [31:0] e_pc, input logic [31:0] e_np,
                                  input logic e_fv, input logic e_fl, input logic e_mis);
        exp_t e;
        @(posedge clock);
        #1;
        resetn        = rst;
        stall         = s;
        imem_ready    = r;
        branch_taken  = bt_en;
        branch_target = bt;
        jump_valid    = jv;
        jump_target   = jt;
        exception     = exc;
        e.idx = step_idx;
        e.pc  = e_pc;
        e.np  = e_np;
        e.fv  = e_fv;
        e.fl  = e_fl;
        e.mis = e_mis;
        exp_q.push_back(e);
        step_idx++;
    endtask

    // Scoreboard monitor: runs away from the active edge and pops one
    // expectation whenever one is pending.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("pc",          e.idx, pc,                  e.pc);
                check_output("next_pc",     e.idx, next_pc,             e.np);
                check_output("fetch_valid", e.idx, {31'd0, fetch_valid}, {31'd0, e.fv});
                check_output("flush",       e.idx, {31'd0, flush},       {31'd0, e.fl});
                check_output("misaligned",  e.idx, {31'd0, misaligned},  {31'd0, e.mis});
            end
        end
    end

    initial begin
        compared      = 0;
        mismatched    = 0;
        step_idx      = 0;
        resetn        = 1'b0;
        stall         = 1'b0;
        imem_ready    = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        jump_valid    = 1'b0;
        jump_target   = 32'd0;
        exception     = 1'b0;

        // Columns: rst stall ready | br bt | jv jt | exc || pc next_pc fv flush mis
        // Reset state, then release into BOOT, then sequential advance.
        apply_stimulus(0, 0, 1, 0, 32'h0,   0, 32'h0, 0, 32'd100, 32'd100, 0, 0, 0);
        apply_stimulus(1, 0, 1, 0, 32'h0,   0, 32'h0, 0, 32'd100, 32'd100, 0, 0, 0);
        apply_stimulus(1, 0, 1, 0, 32'h0,   0, 32'h0, 0, 32'd100, 32'd104, 1, 0, 0);
        apply_stimulus(1, 0, 1, 0, 32'h0,   0, 32'h0, 0, 32'd104, 32'd108, 1, 0, 0);
        // Stall for three cycles at 108, then release.
        apply_stimulus(1, 1, 1, 0, 32'h0,   0, 32'h0, 0, 32'd108, 32'd108, 1, 0, 0);
        apply_stimulus(1, 1, 1, 0, 32'h0,   0, 32'h0, 0, 32'd108, 32'd108, 1, 0, 0);
        apply_stimulus(1, 1, 1, 0, 32'h0,   0, 32'h0, 0, 32'd108, 32'd108, 1, 0, 0);
        apply_stimulus(1, 0, 1, 0, 32'h0,   0, 32'h0, 0, 32'd108, 32'd112, 1, 0, 0);
        // imem_ready low also holds.
        apply_stimulus(1, 0, 0, 0, 32'h0,   0, 32'h0, 0, 32'd112, 32'd112, 1, 0, 0);
        apply_stimulus(1, 0, 1, 0, 32'h0,   0, 32'h0, 0, 32'd112, 32'd116, 1, 0, 0);
        apply_stimulus(1, 0, 1, 0, 32'h0,   0, 32'h0, 0, 32'd116, 32'd120, 1, 0, 0);
        // Branch taken under stall wins, then one bubble with flush.
        apply_stimulus(1, 1, 1, 1, 32'h200, 0, 32'h0, 0, 32'd120,   32'h200, 1, 0, 0);
        apply_stimulus(1, 0, 1, 0, 32'h0,   0, 32'h0, 0, 32'h200,   32'h200, 0, 1, 0);
        apply_stimulus(1, 0, 1, 0, 32'h0,   0, 32'h0, 0, 32'h200,   32'h204, 1, 0, 0);
        // Exception beats jump beats branch. A redirect during REDIRECT is accepted.
        apply_stimulus(1, 0, 1, 1, 32'h400, 1, 32'h300, 1, 32'h204, 32'd8,   1, 0, 0);
        apply_stimulus(1, 0, 1, 1, 32'h400, 1, 32'h300, 0, 32'd8,   32'h300, 0, 1, 0);
        apply_stimulus(1, 0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h300, 32'h300, 0, 1, 0);
        apply_stimulus(1, 0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h300, 32'h304, 1, 0, 0);
        // Misaligned jump target vectors to the trap PC.
        apply_stimulus(1, 0, 1, 0, 32'h0,   1, 32'h302, 0, 32'h304, 32'd8,   1, 0, 0);
        apply_stimulus(1, 0, 1, 0, 32'h0,   0, 32'h0,   0, 32'd8,   32'd8,   0, 1, 1);
        apply_stimulus(1, 0, 1, 0, 32'h0,   0, 32'h0,   0, 32'd8,   32'd12,  1, 0, 0);
        // Misaligned branch target also vectors to the trap PC.
        apply_stimulus(1, 0, 1, 1, 32'h201, 0, 32'h0,   0, 32'd12,  32'd8,   1, 0, 0);
        apply_stimulus(1, 0, 1, 0, 32'h0,   0, 32'h0,   0, 32'd8,   32'd8,   0, 1, 1);
        // Jump to the top of the address space, then wrap on advance.
        apply_stimulus(1, 0, 1, 0, 32'h0,   1, 32'hFFFFFFFC, 0, 32'd8, 32'hFFFFFFFC, 1, 0, 0);
        apply_stimulus(1, 0, 1, 0, 32'h0,   0, 32'h0,   0, 32'hFFFFFFFC, 32'hFFFFFFFC, 0, 1, 0);
        apply_stimulus(1, 0, 1, 0, 32'h0,   0, 32'h0,   0, 32'hFFFFFFFC, 32'h0,        1, 0, 0);
        // Enter REDIRECT again, then reset in the middle of it.
        apply_stimulus(1, 0, 1, 0, 32'h0,   1, 32'h500, 0, 32'h0,   32'h500, 1, 0, 0);
        apply_stimulus(1, 0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h500, 32'h500, 0, 1, 0);

        // Assert reset between edges. Outputs must return to reset values
        // at once, without waiting for a clock edge.
        @(negedge clock);
        #1;
        resetn = 1'b0;
        #1;
        check_output("async_reset_pc",    step_idx, pc,                 32'd100);
        check_output("async_reset_flush", step_idx, {31'd0, flush},       32'd0);
        check_output("async_reset_fv",    step_idx, {31'd0, fetch_valid}, 32'd0);

        apply_stimulus(0, 0, 1, 0, 32'h0,   0, 32'h0,   0, 32'd100, 32'd100, 0, 0, 0);
        apply_stimulus(1, 0, 1, 0, 32'h0,   0, 32'h0,   0, 32'd100, 32'd100, 0, 0, 0);
        apply_stimulus(1, 0, 1, 0, 32'h0,   0, 32'h0,   0, 32'd100, 32'd104, 1, 0, 0);

        // Let the monitor consume the last expectation, then confirm nothing
        // is left over.
        repeat (3) @(negedge clock);
        #1;
        check_output("queue_drained", step_idx, 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
